// File: rtl/hearts_lives.sv
// Lives tracker and heart-icon overlay: FSM for lives/invulnerability plus a registered
// hearts drawing layer evaluated against the current scan coordinate.
module hearts_lives #(
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned HEART_X0      = 16,
    parameter int unsigned HEART_Y0      = 8,
    parameter int unsigned HEART_PITCH   = 24,
    parameter int unsigned INVULN_FRAMES = 64,
    parameter logic [7:0]  HEART_RGB     = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        gameStart,
    input  logic        playerHit,
    output logic        heartsDR,
    output logic [7:0]  heartsRGB,
    output logic [1:0]  livesCount,
    output logic        gameOver
);

    // Counter needs bit 3 for the blink phase even for short immunity windows.
    localparam int unsigned CntW = ($clog2(INVULN_FRAMES + 1) > 4) ?
                                   $clog2(INVULN_FRAMES + 1) : 4;
    localparam logic [CntW-1:0] LastCnt  = CntW'(INVULN_FRAMES - 1);
    localparam logic [1:0]      MaxLives = 2'(MAX_LIVES);

    typedef enum logic [1:0] {StIdle, StAlive, StInvuln, StDead} state_e;

    state_e          state_q, state_d;
    logic [1:0]      lives_q, lives_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dr_q, dr_d;
    logic [7:0]      rgb_q, rgb_d;

    logic [11:0] dx, dy;
    logic [15:0] row;
    logic        drawn;

    function automatic logic [15:0] mask_row(input logic [3:0] r);
        logic [15:0] m;
        case (r)
            4'd1:    m = 16'h381C;
            4'd2:    m = 16'h7C3E;
            4'd3:    m = 16'hFE7F;
            4'd4:    m = 16'hFFFF;
            4'd5:    m = 16'hFFFF;
            4'd6:    m = 16'hFFFF;
            4'd7:    m = 16'h7FFE;
            4'd8:    m = 16'h3FFC;
            4'd9:    m = 16'h1FF8;
            4'd10:   m = 16'h0FF0;
            4'd11:   m = 16'h07E0;
            4'd12:   m = 16'h03C0;
            4'd13:   m = 16'h0180;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            lives_q <= 2'd0;
            cnt_q   <= '0;
            dr_q    <= 1'b0;
            rgb_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            dr_q    <= dr_d;
            rgb_q   <= rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        if (gameStart) begin
            state_d = StAlive;
            lives_d = MaxLives;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StAlive: begin
                    if (playerHit) begin
                        cnt_d = '0;
                        if (lives_q <= 2'd1) begin
                            state_d = StDead;
                            lives_d = 2'd0;
                        end else begin
                            state_d = StInvuln;
                            lives_d = lives_q - 2'd1;
                        end
                    end
                end
                StInvuln: begin
                    if (startOfFrame) begin
                        if (cnt_q == LastCnt) begin
                            state_d = StAlive;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StIdle, StDead: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Heart i is drawn when alive-count covers it, or it is the blinking lost heart.
    always_comb begin
        dr_d  = 1'b0;
        dx    = '0;
        dy    = '0;
        row   = '0;
        drawn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dx    = {1'b0, pixelX} - 12'(HEART_X0 + i * HEART_PITCH);
            dy    = {1'b0, pixelY} - 12'(HEART_Y0);
            row   = mask_row(dy[3:0]);
            drawn = (2'(i) < lives_q) ||
                    (state_q == StInvuln && 2'(i) == lives_q && !cnt_q[3]);
            if (dx < 12'd16 && dy < 12'd16 && drawn && row[dx[3:0]]) begin
                dr_d = 1'b1;
            end
        end
        rgb_d = dr_d ? HEART_RGB : 8'h00;
    end

    assign heartsDR   = dr_q;
    assign heartsRGB  = rgb_q;
    assign livesCount = lives_q;
    assign gameOver   = (state_q == StDead);

endmodule

// File: tb/tb_hearts_lives.sv
// Scoreboard bench for hearts_lives: driver pushes model expectations, monitor compares.
module tb_hearts_lives;
    localparam int MAXL = 3;
    localparam int X0   = 16;
    localparam int Y0   = 8;
    localparam int P    = 24;
    localparam int INV  = 64;
    localparam logic [7:0] RGB = 8'hE0;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] px, py;
    logic        sof, gs, hit;
    logic        heartsDR;
    logic [7:0]  heartsRGB;
    logic [1:0]  livesCount;
    logic        gameOver;

    always #5 clk = ~clk;

    hearts_lives #(
        .MAX_LIVES(MAXL), .HEART_X0(X0), .HEART_Y0(Y0), .HEART_PITCH(P),
        .INVULN_FRAMES(INV), .HEART_RGB(RGB)
    ) dut (
        .clk(clk), .reset(reset), .pixelX(px), .pixelY(py),
        .startOfFrame(sof), .gameStart(gs), .playerHit(hit),
        .heartsDR(heartsDR), .heartsRGB(heartsRGB),
        .livesCount(livesCount), .gameOver(gameOver)
    );

    typedef struct {
        bit          dr;
        logic [7:0]  rgb;
        int          lives;
        bit          go;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain game rules
    bit m_started, m_inv, m_dead;
    int m_lives, m_frames;

    logic [15:0] tb_mask [16] = '{16'h0000, 16'h381C, 16'h7C3E, 16'hFE7F,
                                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
                                  16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0,
                                  16'h03C0, 16'h0180, 16'h0000, 16'h0000};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pixel(input int x, input int y);
        logic [15:0] r;
        for (int i = 0; i < 3; i++) begin
            int hx = X0 + i * P;
            if (x >= hx && x < hx + 16 && y >= Y0 && y < Y0 + 16) begin
                r = tb_mask[y - Y0];
                if (r[x - hx] &&
                    (i < m_lives || (m_inv && i == m_lives && (m_frames % 16) < 8)))
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_inv = 0; m_dead = 0; m_lives = 0; m_frames = 0;
    endtask

    task automatic step(input int x, input int y, input bit s, input bit g, input bit h);
        exp_t e;
        @(negedge clk);
        px = 11'(x); py = 11'(y); sof = s; gs = g; hit = h;
        e.dr  = model_pixel(x, y);
        e.rgb = e.dr ? RGB : 8'h00;
        if (g) begin
            m_started = 1; m_lives = MAXL; m_inv = 0; m_dead = 0; m_frames = 0;
        end else if (m_started && !m_dead && !m_inv && h) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_dead = 1;
            else begin m_inv = 1; m_frames = 0; end
        end else if (m_inv && s) begin
            if (m_frames == INV - 1) m_inv = 0;
            else m_frames++;
        end
        e.lives = m_lives;
        e.go    = m_dead;
        sbq.push_back(e);
    endtask

    task automatic frames(input int n, input int x, input int y);
        for (int f = 0; f < n; f++) begin
            step(x, y, 1'b1, 1'b0, 1'b0);
            step(x, y, 1'b0, 1'b0, 1'b0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("heartsDR", int'(heartsDR), int'(mon_e.dr));
            check("heartsRGB", int'(heartsRGB), int'(mon_e.rgb));
            check("livesCount", int'(livesCount), mon_e.lives);
            check("gameOver", int'(gameOver), int'(mon_e.go));
        end
    end

    initial begin
        int c0x, c2x, cy;
        c0x = X0 + 8; c2x = X0 + 2 * P + 8; cy = Y0 + 8;
        reset = 1'b1; px = '0; py = '0; sof = 0; gs = 0; hit = 0;
        model_reset();
        #3;
        check("rst_dr", int'(heartsDR), 0);
        check("rst_rgb", int'(heartsRGB), 0);
        check("rst_lives", int'(livesCount), 0);
        check("rst_go", int'(gameOver), 0);
        @(negedge clk); reset = 1'b0;

        // Idle ignores hits; start then scan heart 0 centre
        step(c0x, cy, 0, 0, 1);
        step(c0x, cy, 0, 1, 0);
        step(c0x, cy, 0, 0, 0);
        @(posedge clk); #2;
        check("start_dr", int'(heartsDR), 1);
        check("start_rgb", int'(heartsRGB), 32'hE0);
        check("start_lives", int'(livesCount), 3);

        // Hit, ignored second hit 5 frames in, blink of heart 2, recovery
        step(c2x, cy, 0, 0, 1);
        for (int f = 0; f < 70; f++) begin
            step(c2x, cy, 1, 0, f == 5);
            step(c2x, cy, 0, 0, 0);
        end
        @(posedge clk); #2;
        check("recover_lives", int'(livesCount), 2);

        // Run out of lives, then restart
        step(c0x, cy, 0, 0, 1);
        frames(66, c2x, cy);
        step(c0x, cy, 0, 0, 1);
        frames(66, c0x, cy);
        for (int i = 0; i < 3; i++) step(X0 + i * P + 8, cy, 0, 0, 0);
        @(posedge clk); #2;
        check("dead_go", int'(gameOver), 1);
        check("dead_lives", int'(livesCount), 0);
        check("dead_dr", int'(heartsDR), 0);
        step(c0x, cy, 0, 1, 0);

        // gameStart wins over playerHit at one life
        step(c0x, cy, 0, 0, 1);
        frames(65, c0x, cy);
        step(c0x, cy, 0, 0, 1);
        frames(65, c0x, cy);
        step(c0x, cy, 0, 1, 1);
        @(posedge clk); #2;
        check("prio_lives", int'(livesCount), 3);
        check("prio_go", int'(gameOver), 0);

        // Corner pixel, far out-of-range pixel, reset mid-invulnerability
        step(X0, Y0, 0, 0, 0);
        step(2047, 2047, 0, 0, 0);
        step(c0x, cy, 0, 0, 1);
        frames(3, c0x, cy);
        @(posedge clk); #2;
        check("prerst_dr", int'(heartsDR), 1);
        reset = 1'b1;
        #1;
        check("midrst_dr", int'(heartsDR), 0);
        check("midrst_rgb", int'(heartsRGB), 0);
        check("midrst_lives", int'(livesCount), 0);
        check("midrst_go", int'(gameOver), 0);
        @(negedge clk); reset = 1'b0;
        model_reset();
        step(c0x, cy, 1, 0, 1);
        step(c0x, cy, 0, 0, 0);

        // Randomized play
        for (int n = 0; n < 3000; n++) begin
            int x, y;
            if ($urandom_range(0, 15) == 0) begin x = 2047; y = 2047; end
            else begin x = $urandom_range(0, 100); y = $urandom_range(0, 30); end
            step(x, y, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0);
        end

        @(posedge clk); #2;
        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
